// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the CPU port, the DMA port and the single-port memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port memory with fixed read latency.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX back-to-back CPU wins over a waiting DMA, DMA wins once.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       owner_dma, owner_dma_nxt;
   logic       grant_cpu, grant_dma;
   logic       issue_we;
   logic       starve_force;

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $fatal(1, "mem_port_arbiter: RD_LAT must be in 1..4");
      end
      if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
         $fatal(1, "mem_port_arbiter: STARVE_MAX must fit the 3-bit starvation counter (1..7)");
      end
   endgenerate

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt;

   // Counts CPU wins that left a requesting DMA waiting; any DMA win or idle DMA clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!bus.dma_req || grant_dma) begin
         starve_cnt <= '0;
      end else if (grant_cpu) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign starve_force = (starve_cnt == 3'(STARVE_MAX));
`else
   assign starve_force = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         owner_dma <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         owner_dma <= owner_dma_nxt;
      end
   end

   // Outputs are held quiet while reset is asserted so nothing leaks during an async reset.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      owner_dma_nxt  = owner_dma;
      grant_cpu      = 1'b0;
      grant_dma      = 1'b0;
      issue_we       = 1'b0;
      bus.cpu_gnt    = 1'b0;
      bus.dma_gnt    = 1'b0;
      bus.cpu_rvalid = 1'b0;
      bus.dma_rvalid = 1'b0;
      bus.cpu_rdata  = '0;
      bus.dma_rdata  = '0;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;

      if (!reset) begin
         case (state)
            IDLE: begin
               grant_dma = bus.dma_req && (!bus.cpu_req || starve_force);
               grant_cpu = bus.cpu_req && !grant_dma;
               if (grant_dma) begin
                  issue_we      = bus.dma_we;
                  bus.mem_addr  = bus.dma_addr;
                  bus.mem_wdata = bus.dma_wdata;
               end else if (grant_cpu) begin
                  issue_we      = bus.cpu_we;
                  bus.mem_addr  = bus.cpu_addr;
                  bus.mem_wdata = bus.cpu_wdata;
               end
               bus.cpu_gnt = grant_cpu;
               bus.dma_gnt = grant_dma;
               bus.mem_en  = grant_cpu || grant_dma;
               bus.mem_we  = issue_we;
               // Writes retire in the issue cycle; only reads occupy the port.
               if ((grant_cpu || grant_dma) && !issue_we) begin
                  state_nxt     = RD_WAIT;
                  cnt_nxt       = 3'(RD_LAT);
                  owner_dma_nxt = grant_dma;
               end
            end
            RD_WAIT: begin
               cnt_nxt = cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state_nxt = IDLE;
                  if (owner_dma) begin
                     bus.dma_rvalid = 1'b1;
                     bus.dma_rdata  = bus.mem_rdata;
                  end else begin
                     bus.cpu_rvalid = 1'b1;
                     bus.cpu_rdata  = bus.mem_rdata;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model that tracks outstanding reads by absolute return cycle.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int RD_LAT     = 3;
   localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model state
   bit rd_out = 1'b0;
   int rd_at = 0;
   bit rd_dma = 1'b0;
   int streak = 0;
   bit seen_cg = 1'b0;
   bit seen_dg = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic eval_cycle();
      logic        ecg, edg, een, ewe, ecrv, edrv;
      logic [31:0] eaddr, ewd, ecrd, edrd;
      ecg = 0; edg = 0; een = 0; ewe = 0; ecrv = 0; edrv = 0;
      eaddr = '0; ewd = '0; ecrd = '0; edrd = '0;
      if (reset) begin
         rd_out = 1'b0;
         streak = 0;
      end else begin
         if (rd_out) begin
            if (cyc == rd_at) begin
               if (rd_dma) begin edrv = 1; edrd = bus.mem_rdata; end
               else        begin ecrv = 1; ecrd = bus.mem_rdata; end
               rd_out = 1'b0;
            end
         end else begin
            edg = bus.dma_req && (!bus.cpu_req || (GUARD && streak == STARVE_MAX));
            ecg = bus.cpu_req && !edg;
            if (edg) begin
               een = 1; ewe = bus.dma_we; eaddr = bus.dma_addr; ewd = bus.dma_wdata;
            end else if (ecg) begin
               een = 1; ewe = bus.cpu_we; eaddr = bus.cpu_addr; ewd = bus.cpu_wdata;
            end
            if (een && !ewe) begin
               rd_out = 1'b1;
               rd_at  = cyc + RD_LAT;
               rd_dma = edg;
            end
         end
         if (!bus.dma_req || edg) streak = 0;
         else if (ecg)            streak++;
      end
      check_val("cpu_gnt",    64'(bus.cpu_gnt),    64'(ecg));
      check_val("dma_gnt",    64'(bus.dma_gnt),    64'(edg));
      check_val("mem_en",     64'(bus.mem_en),     64'(een));
      check_val("mem_we",     64'(bus.mem_we),     64'(ewe));
      check_val("mem_addr",   64'(bus.mem_addr),   64'(eaddr));
      check_val("mem_wdata",  64'(bus.mem_wdata),  64'(ewd));
      check_val("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(ecrv));
      check_val("cpu_rdata",  64'(bus.cpu_rdata),  64'(ecrd));
      check_val("dma_rvalid", 64'(bus.dma_rvalid), 64'(edrv));
      check_val("dma_rdata",  64'(bus.dma_rdata),  64'(edrd));
      seen_cg = bus.cpu_gnt;
      seen_dg = bus.dma_gnt;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet_inputs();
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
   endtask

   initial begin
      int gap;
      int ndg;
      bit found;
      bit c_act;
      bit d_act;

      reset = 1'b1;
      quiet_inputs();
      bus.mem_rdata = '0;
      repeat (2) run_cycle();
      reset = 1'b0;
      repeat (2) run_cycle();

      // CPU read at 0x10, memory returns 0xDEADBEEF
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
      bus.mem_rdata = 32'hDEADBEEF;
      run_cycle();
      check_val("cpu_rd_issue", 64'(seen_cg), 64'd1);
      bus.cpu_req = 0;
      repeat (RD_LAT + 1) run_cycle();

      // Simultaneous writes: CPU first, DMA next cycle
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h5;
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h24; bus.dma_wdata = 32'h7;
      run_cycle();
      check_val("simwr_c0_cpu", 64'(seen_cg), 64'd1);
      bus.cpu_req = 0;
      run_cycle();
      check_val("simwr_c1_dma", 64'(seen_dg), 64'd1);
      quiet_inputs();
      run_cycle();

      // DMA read at 0x40, CPU request raised the following cycle
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h40;
      run_cycle();
      bus.dma_req = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h44;
      gap = 1; found = 0;
      for (int i = 0; i < 20; i++) begin
         bus.mem_rdata = $urandom;
         run_cycle();
         if (seen_cg) begin found = 1; break; end
         gap++;
      end
      check_val("cpu_after_dma_found", 64'(found), 64'd1);
      check_val("cpu_after_dma_gap", 64'(gap), 64'(RD_LAT + 1));
      quiet_inputs();
      repeat (RD_LAT + 1) run_cycle();

      // Reset one cycle into a CPU read: read is discarded
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h80;
      run_cycle();
      bus.cpu_req = 0;
      run_cycle();
      reset = 1'b1;
      repeat (2) run_cycle();
      reset = 1'b0;
      repeat (RD_LAT + 2) run_cycle();
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h84; bus.cpu_wdata = 32'h1;
      run_cycle();
      check_val("post_reset_gnt", 64'(seen_cg), 64'd1);
      quiet_inputs();
      run_cycle();

      // Both ports streaming writes
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'hA;
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h200; bus.dma_wdata = 32'hB;
      ndg = 0;
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         if (seen_dg) ndg++;
      end
      check_val("stream_dma_grants", 64'(ndg), GUARD ? 64'(10 / (STARVE_MAX + 1)) : 64'd0);
      quiet_inputs();
      run_cycle();

      // Random traffic with occasional drops and resets
      c_act = 0; d_act = 0;
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         bus.mem_rdata = $urandom;
         if (c_act && seen_cg) c_act = 0;
         if (!c_act) begin
            if ($urandom_range(0, 2) != 0) begin
               c_act = 1;
               bus.cpu_we = 1'($urandom_range(0, 1));
               bus.cpu_addr = $urandom;
               bus.cpu_wdata = $urandom;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            c_act = 0;
         end
         if (d_act && seen_dg) d_act = 0;
         if (!d_act) begin
            if ($urandom_range(0, 2) != 0) begin
               d_act = 1;
               bus.dma_we = 1'($urandom_range(0, 1));
               bus.dma_addr = $urandom;
               bus.dma_wdata = $urandom;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            d_act = 0;
         end
         bus.cpu_req = c_act;
         bus.dma_req = d_act;
         run_cycle();
      end
      reset = 1'b0;
      quiet_inputs();
      repeat (RD_LAT + 2) run_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multi-cycle CPU between two requesters: the CPU memory port and a DMA/loader port.
- Issues one memory transaction at a time and returns read data to the owning requester after a fixed latency.
- The CPU controller stalls its FSM while its request is pending and not yet granted.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles, legal range 1..4
STARVE_MAX, 4, consecutive CPU grants tolerated while DMA waits; used only with ARB_STARVE_GUARD_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cpu_req  in  1  CPU request; held with stable we/addr/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse; CPU transaction issued this cycle
cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
cpu_rdata  out  DATA_W  read data to CPU
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same semantics for DMA
dma_gnt, dma_rvalid  out  1  same semantics for DMA
dma_rdata  out  DATA_W  read data to DMA
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the mem_en read cycle

Behaviour:
- Reset: clk and reset as already decided (clock clk; reset asynchronous, active-high).
  - State goes to IDLE; counters are cleared; owner goes to CPU.
  - All outputs are 0 during and after reset until a request arrives.
- FSM states: IDLE, RD_WAIT.
- IDLE:
  - Arbitration is combinational over cpu_req/dma_req. Default: CPU wins on simultaneous requests.
  - The winner's gnt is 1 in the same cycle.
  - mem_en=1, and mem_we/mem_addr/mem_wdata are driven from the winner in the same cycle.
  - Write: complete in the issue cycle; stay IDLE, so back-to-back issue is possible every cycle.
  - Read: record the owner, load cnt=RD_LAT, go to RD_WAIT.
  - No request: mem_en=0 and mem_* outputs are 0.
- RD_WAIT:
  - No grants and mem_en=0; pending requests wait.
  - cnt decrements each cycle. In the cycle where cnt==1:
    - owner's rvalid=1 and owner's rdata=mem_rdata (pass-through);
    - the non-owner's rdata=0;
    - next state is IDLE.
  - Read-to-read issue spacing is therefore RD_LAT+1 cycles.
- rdata outputs are 0 whenever their rvalid is 0.
- A requester may drop req before its gnt; no grant is issued and no state change occurs.
- gnt is never asserted to a requester whose req is 0.
- Reset mid-read: the outstanding read is discarded, no rvalid is emitted, and the FSM returns to IDLE.
- RD_LAT outside 1..4 is illegal; an elaboration-time check stops simulation.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A 3-bit counter increments on each CPU grant issued while dma_req=1.
  - The counter clears on a DMA grant, or on any cycle with dma_req=0.
  - When the counter equals STARVE_MAX, the next IDLE arbitration with both requests pending grants DMA.
- Undefined: pure fixed CPU priority; the counter logic is absent.

Test Plan:
- CPU read only, addr=0x10, memory returns 0xDEADBEEF, RD_LAT=1 -> cpu_gnt and mem_en in cycle 0; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1; dma outputs stay 0.
- Simultaneous CPU write (addr 0x20, data 0x5) and DMA write (addr 0x24, data 0x7), both held -> cycle 0: cpu_gnt, mem_addr=0x20; cycle 1: dma_gnt, mem_addr=0x24, mem_wdata=0x7.
- RD_LAT=3, DMA read at 0x40 then CPU request raised the next cycle -> dma_rvalid 3 cycles after issue; cpu_gnt no earlier than 4 cycles after the DMA issue.
- Reset asserted 1 cycle into an RD_LAT=3 CPU read -> no cpu_rvalid ever; all outputs 0; next CPU request granted immediately after reset release.
- ARB_STARVE_GUARD_EN, STARVE_MAX=4, CPU and DMA continuously requesting writes -> grant sequence CPU, CPU, CPU, CPU, DMA, repeating; without the macro -> CPU only, dma_gnt never 1.
